// File: rtl/shift_issue_if.sv
// Bundles the request, SHIFT start/done and writeback signals of the issue controller.
interface shift_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [31:0] req_imm;
  logic [1:0]  req_use_part;
  logic [1:0]  req_mode1;
  logic [2:0]  req_mode2;
  logic [4:0]  req_rd;

  logic        sh_start;
  logic [31:0] sh_op1;
  logic [31:0] sh_op2;
  logic [31:0] sh_imm_data;
  logic [1:0]  sh_use_part;
  logic [1:0]  sh_op_mode1;
  logic [2:0]  sh_op_mode2;
  logic        sh_done;
  logic [31:0] sh_res;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_err;

  logic        busy;

  // Controller view
  modport master (
    input  req_valid, req_op1, req_op2, req_imm, req_use_part, req_mode1, req_mode2, req_rd,
    output req_ready,
    output sh_start, sh_op1, sh_op2, sh_imm_data, sh_use_part, sh_op_mode1, sh_op_mode2,
    input  sh_done, sh_res,
    output wb_valid, wb_data, wb_rd, wb_err,
    input  wb_ready,
    output busy
  );

  // Decode stage, SHIFT unit and writeback stage view
  modport slave (
    output req_valid, req_op1, req_op2, req_imm, req_use_part, req_mode1, req_mode2, req_rd,
    input  req_ready,
    input  sh_start, sh_op1, sh_op2, sh_imm_data, sh_use_part, sh_op_mode1, sh_op_mode2,
    output sh_done, sh_res,
    input  wb_valid, wb_data, wb_rd, wb_err,
    output wb_ready,
    input  busy
  );
endinterface

// File: rtl/shift_issue_ctrl.sv
// Issues one shift request at a time to SHIFT, waits for done or timeout,
// and presents the result (or a timeout error) on the writeback port.
module shift_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic          clk,
  input logic          rst,
  shift_issue_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [31:0]      imm_q, imm_d;
  logic [1:0]       use_part_q, use_part_d;
  logic [1:0]       mode1_q, mode1_d;
  logic [2:0]       mode2_q, mode2_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_err_q, wb_err_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and holding registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      use_part_q <= '0;
      mode1_q    <= '0;
      mode2_q    <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm_d;
      use_part_q <= use_part_d;
      mode1_q    <= mode1_d;
      mode2_q    <= mode2_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

  // Next-state and register update logic; sh_done only matters in WAIT
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    imm_d      = imm_q;
    use_part_d = use_part_q;
    mode1_d    = mode1_q;
    mode2_d    = mode2_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op1_d      = bus.req_op1;
          op2_d      = bus.req_op2;
          imm_d      = bus.req_imm;
          use_part_d = bus.req_use_part;
          mode1_d    = bus.req_mode1;
          mode2_d    = bus.req_mode2;
          rd_d       = bus.req_rd;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.sh_done) begin
          wb_data_d = bus.sh_res;
          wb_err_d  = 1'b0;
          state_d   = S_WB;
        end else if (timeout) begin
          wb_data_d = '0;
          wb_err_d  = 1'b1;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (bus.wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state
  assign bus.req_ready   = (state_q == S_IDLE) && rst;
  assign bus.sh_start    = (state_q == S_ISSUE);
  assign bus.wb_valid    = (state_q == S_WB);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sh_op1      = op1_q;
  assign bus.sh_op2      = op2_q;
  assign bus.sh_imm_data = imm_q;
  assign bus.sh_use_part = use_part_q;
  assign bus.sh_op_mode1 = mode1_q;
  assign bus.sh_op_mode2 = mode2_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl with a small SHIFT result model.
module tb_shift_issue_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   start_cnt;

  shift_issue_if bus_if();

  shift_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses seen at active edges
  always @(posedge clk) if (bus_if.sh_start === 1'b1) start_cnt++;

  // SHIFT model: mode1=2'b10 selects the immediate amount, mode2=3'b100 is SRA, else SLL
  function automatic logic [31:0] model_shift(input logic [31:0] op1, input logic [31:0] op2,
                                              input logic [31:0] imm, input logic [1:0] m1,
                                              input logic [2:0] m2);
    logic [4:0] amt;
    amt = (m1 == 2'b10) ? imm[4:0] : op2[4:0];
    if (m2 == 3'b100) return 32'($signed(op1) >>> amt);
    return op1 << amt;
  endfunction

  // Presents a request for one edge; returns at the negedge of the ISSUE cycle
  task automatic send_req(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                          input logic [1:0] up, input logic [1:0] m1, input logic [2:0] m2,
                          input logic [4:0] rd);
    bus_if.req_op1 = op1; bus_if.req_op2 = op2; bus_if.req_imm = imm;
    bus_if.req_use_part = up; bus_if.req_mode1 = m1; bus_if.req_mode2 = m2; bus_if.req_rd = rd;
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic drive_done_model();
    bus_if.sh_done = 1'b1;
    bus_if.sh_res  = model_shift(bus_if.sh_op1, bus_if.sh_op2, bus_if.sh_imm_data,
                                 bus_if.sh_op_mode1, bus_if.sh_op_mode2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus_if.req_ready); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_if.busy); end
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.sh_start !== 1'b0) begin errors++; $display("FAIL reset_valids got %b%b exp 00", bus_if.wb_valid, bus_if.sh_start); end
    checks++; if (bus_if.wb_data !== 32'h0 || bus_if.sh_op1 !== 32'h0 || bus_if.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", bus_if.wb_data, bus_if.sh_op1, bus_if.wb_rd); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus_if.req_ready); end
  endtask

  task automatic test_basic_sra();
    int s0;
    s0 = start_cnt;
    send_req(32'h9000_0000, 32'd2, 32'd0, 2'b00, 2'b00, 3'b100, 5'd5);
    checks++; if (bus_if.sh_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b exp 1", bus_if.sh_start); end
    checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_issue got %b exp 0", bus_if.req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_if.sh_start !== 1'b0 || bus_if.wb_valid !== 1'b0 || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL basic_wait%0d ctl got %b%b%b exp 000", i, bus_if.sh_start, bus_if.wb_valid, bus_if.req_ready); end
      checks++; if (bus_if.sh_op1 !== 32'h9000_0000 || bus_if.sh_op2 !== 32'd2 || bus_if.sh_op_mode2 !== 3'b100) begin errors++; $display("FAIL basic_wait%0d ops got %h %h %b exp 90000000 2 100", i, bus_if.sh_op1, bus_if.sh_op2, bus_if.sh_op_mode2); end
    end
    drive_done_model();
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_err !== 1'b0) begin errors++; $display("FAIL basic_wb_flags got %b%b exp 10", bus_if.wb_valid, bus_if.wb_err); end
    checks++; if (bus_if.wb_data !== 32'hE400_0000) begin errors++; $display("FAIL basic_wb_data got %h exp e4000000", bus_if.wb_data); end
    checks++; if (bus_if.wb_rd !== 5'd5) begin errors++; $display("FAIL basic_wb_rd got %0d exp 5", bus_if.wb_rd); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_count got %0d exp 1", start_cnt - s0); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.req_ready !== 1'b1 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL basic_return got %b%b%b exp 010", bus_if.wb_valid, bus_if.req_ready, bus_if.busy); end
  endtask

  task automatic test_back_to_back();
    send_req(32'h0000_0010, 32'h0000_001F, 32'd3, 2'b01, 2'b10, 3'b000, 5'd9);
    checks++; if (bus_if.sh_imm_data !== 32'd3 || bus_if.sh_op_mode1 !== 2'b10 || bus_if.sh_use_part !== 2'b01) begin errors++; $display("FAIL imm_issue got %h %b %b exp 3 10 01", bus_if.sh_imm_data, bus_if.sh_op_mode1, bus_if.sh_use_part); end
    @(negedge clk);
    checks++; if (bus_if.sh_imm_data !== 32'd3) begin errors++; $display("FAIL imm_wait_hold got %h exp 3", bus_if.sh_imm_data); end
    drive_done_model();
    // second request waits while the first sits in WB
    bus_if.req_op1 = 32'h0000_0001; bus_if.req_op2 = 32'd4; bus_if.req_imm = 32'd0;
    bus_if.req_use_part = 2'b00; bus_if.req_mode1 = 2'b00; bus_if.req_mode2 = 3'b000; bus_if.req_rd = 5'd12;
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    bus_if.req_valid = 1'b1;
    checks++; if (bus_if.wb_data !== 32'h0000_0080 || bus_if.wb_rd !== 5'd9) begin errors++; $display("FAIL imm_wb got %h rd %0d exp 00000080 rd 9", bus_if.wb_data, bus_if.wb_rd); end
    checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_wb got %b exp 0", bus_if.req_ready); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0 || bus_if.sh_op1 !== 32'h0000_0010) begin errors++; $display("FAIL b2b_idle got busy %b op1 %h exp 0 00000010", bus_if.busy, bus_if.sh_op1); end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    checks++; if (bus_if.sh_start !== 1'b1 || bus_if.sh_op1 !== 32'h0000_0001) begin errors++; $display("FAIL b2b_second_issue got %b %h exp 1 00000001", bus_if.sh_start, bus_if.sh_op1); end
    @(negedge clk);
    drive_done_model();
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_data !== 32'h0000_0010 || bus_if.wb_rd !== 5'd12) begin errors++; $display("FAIL b2b_second_wb got %b %h %0d exp 1 00000010 12", bus_if.wb_valid, bus_if.wb_data, bus_if.wb_rd); end
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_return got %b%b exp 00", bus_if.busy, bus_if.wb_valid); end
  endtask

  task automatic test_timeout();
    send_req(32'h1234_5678, 32'd1, 32'd0, 2'b00, 2'b00, 3'b000, 5'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL timeout_wait%0d got %b%b exp 01", i, bus_if.wb_valid, bus_if.busy); end
    end
    @(negedge clk);
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_err !== 1'b1 || bus_if.wb_data !== 32'h0) begin errors++; $display("FAIL timeout_wb got %b %b %h exp 1 1 00000000", bus_if.wb_valid, bus_if.wb_err, bus_if.wb_data); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
    // done in the last WAIT cycle beats the timeout
    send_req(32'h0000_0003, 32'd4, 32'd0, 2'b00, 2'b00, 3'b000, 5'd8);
    for (int i = 0; i < 8; i++) @(negedge clk);
    bus_if.sh_done = 1'b1;
    bus_if.sh_res  = 32'hCAFE_0030;
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_err !== 1'b0 || bus_if.wb_data !== 32'hCAFE_0030) begin errors++; $display("FAIL timeout_done_last got %b %b %h exp 1 0 cafe0030", bus_if.wb_valid, bus_if.wb_err, bus_if.wb_data); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int s0;
    send_req(32'h8000_0001, 32'd1, 32'd0, 2'b00, 2'b00, 3'b000, 5'd17);
    @(negedge clk);
    drive_done_model();
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    bus_if.req_valid = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_data !== 32'h0000_0002 || bus_if.wb_rd !== 5'd17 || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %b %h %0d %b exp 1 00000002 17 0", i, bus_if.wb_valid, bus_if.wb_data, bus_if.wb_rd, bus_if.req_ready); end
      @(negedge clk);
    end
    bus_if.req_valid = 1'b0;
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL bp_no_start got %0d exp %0d", start_cnt, s0); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b%b exp 00", bus_if.busy, bus_if.wb_valid); end
  endtask

  task automatic test_reset_mid_wait();
    send_req(32'hFFFF_0000, 32'd3, 32'd5, 2'b11, 2'b01, 3'b010, 5'd21);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.req_ready !== 1'b0 || bus_if.sh_start !== 1'b0) begin errors++; $display("FAIL rstw_ctl got %b%b%b exp 000", bus_if.busy, bus_if.req_ready, bus_if.sh_start); end
    checks++; if (bus_if.sh_op1 !== 32'h0 || bus_if.sh_imm_data !== 32'h0 || bus_if.wb_rd !== 5'd0 || bus_if.wb_data !== 32'h0) begin errors++; $display("FAIL rstw_data got %h %h %0d %h exp 0", bus_if.sh_op1, bus_if.sh_imm_data, bus_if.wb_rd, bus_if.wb_data); end
    @(negedge clk);
    rst = 1'b1;
    bus_if.sh_done = 1'b1;
    bus_if.sh_res  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rstw_late_done%0d got %b%b exp 00", i, bus_if.wb_valid, bus_if.busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_stale_done();
    bus_if.sh_done = 1'b1;
    bus_if.sh_res  = 32'h1111_1111;
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.wb_valid !== 1'b0) begin errors++; $display("FAIL stale_idle got %b%b exp 00", bus_if.busy, bus_if.wb_valid); end
    send_req(32'h0000_00FF, 32'd1, 32'd0, 2'b00, 2'b00, 3'b000, 5'd0);
    bus_if.sh_done = 1'b1;
    @(negedge clk);
    bus_if.sh_done = 1'b0;
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL stale_issue got %b%b exp 01", bus_if.wb_valid, bus_if.busy); end
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++; if (bus_if.wb_valid !== 1'b0) begin errors++; $display("FAIL stale_last_wait got %b exp 0", bus_if.wb_valid); end
    @(negedge clk);
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_err !== 1'b1 || bus_if.wb_rd !== 5'd0) begin errors++; $display("FAIL stale_timeout_rd0 got %b %b %0d exp 1 1 0", bus_if.wb_valid, bus_if.wb_err, bus_if.wb_rd); end
    bus_if.wb_ready = 1'b1;
    @(negedge clk);
    bus_if.wb_ready = 1'b0;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL stale_rd0_return got %b exp 0", bus_if.busy); end
  endtask

  initial begin
    checks = 0; errors = 0; start_cnt = 0;
    rst = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_op1 = '0; bus_if.req_op2 = '0; bus_if.req_imm = '0;
    bus_if.req_use_part = '0; bus_if.req_mode1 = '0; bus_if.req_mode2 = '0; bus_if.req_rd = '0;
    bus_if.sh_done = 1'b0; bus_if.sh_res = '0; bus_if.wb_ready = 1'b0;
    test_reset();
    test_basic_sra();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_stale_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
